// File: rtl/greedysnake_pkg.sv
// Shared constants for the snake renderer, its 720p timing generator and the
// HDMI loopback capture.
package greedysnake_pkg;

  // 720p60 timing
  localparam int H_ACTIVE = 1280;
  localparam int H_FP     = 110;
  localparam int H_SYNC   = 40;
  localparam int H_BP     = 220;
  localparam int V_ACTIVE = 720;
  localparam int V_FP     = 5;
  localparam int V_SYNC   = 5;
  localparam int V_BP     = 20;

  // Map geometry
  localparam int MAP_N     = 16;
  localparam int MAP_ORG_X = 320;
  localparam int MAP_ORG_Y = 40;
  localparam int CELL_PX   = 40;

  // Colours, {B,G,R}
  localparam logic [23:0] BLACK = 24'h000000;
  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] RED   = 24'h0000FF;
  localparam logic [23:0] GREEN = 24'h00FF00;
  localparam logic [23:0] BLUE  = 24'hFF0000;
  localparam logic [23:0] GRAY  = 24'h646464;

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    ACTIVE  = 2'd1,
    COMMIT  = 2'd2
  } cap_state_t;

endpackage

// File: rtl/greedysnake_cell_sampler.sv
// Tracks the pixel position of the registered stream and raises a strobe on
// the centre pixel of each map cell, walking cells in raster order.
module greedysnake_cell_sampler
  import greedysnake_pkg::*;
#(
  parameter int H_RES  = H_ACTIVE,
  parameter int V_RES  = V_ACTIVE,
  parameter int MAP_X0 = MAP_ORG_X,
  parameter int MAP_Y0 = MAP_ORG_Y,
  parameter int CELL   = CELL_PX
) (
  input  logic       I_pxl_clk,
  input  logic       I_rst_n,
  input  logic       clr,       // frame restart: clears y/row/col state
  input  logic       line_rst,  // between lines: reload column target
  input  logic       de,
  input  logic       en,        // sampling allowed this cycle
  output logic       smp,
  output logic [3:0] col,
  output logic [3:0] row_idx
);

  localparam logic [11:0] HS0  = 12'(MAP_X0 + CELL/2);
  localparam logic [11:0] VS0  = 12'(MAP_Y0 + CELL/2);
  localparam logic [11:0] STEP = 12'(CELL);
  localparam logic [11:0] XLIM = 12'(H_RES);
  localparam logic [11:0] YLIM = 12'(V_RES);
  localparam logic [3:0]  LAST = 4'(MAP_N - 1);

  logic [11:0] x_cnt, y_cnt, hs_cmp, vs_cmp;
  logic [4:0]  row;
  logic        de_q, row_done;
  logic        de_fall;

  assign de_fall = de_q & ~de;
  assign row_idx = row[3:0];

  // row_done blocks a second pass of samples on a long line once column 15
  // has been taken; the row target only advances after that line ends.
  assign smp = en && de && !row_done && !row[4] &&
               (x_cnt == hs_cmp) && (y_cnt == vs_cmp) &&
               (x_cnt < XLIM) && (y_cnt < YLIM);

  // position counters, running sample targets and cell index
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      de_q     <= 1'b0;
      x_cnt    <= '0;
      y_cnt    <= '0;
      hs_cmp   <= HS0;
      vs_cmp   <= VS0;
      col      <= '0;
      row      <= '0;
      row_done <= 1'b0;
    end else begin
      de_q <= de;
      if (!de)                x_cnt <= '0;
      else if (x_cnt != '1)   x_cnt <= x_cnt + 12'd1;

      if (clr || line_rst)    hs_cmp <= HS0;
      else if (smp)           hs_cmp <= hs_cmp + STEP;

      if (clr) begin
        y_cnt    <= '0;
        vs_cmp   <= VS0;
        col      <= '0;
        row      <= '0;
        row_done <= 1'b0;
      end else begin
        if (de_fall) begin
          if (y_cnt != '1) y_cnt <= y_cnt + 12'd1;
          if (row_done)    vs_cmp <= vs_cmp + STEP;
          row_done <= 1'b0;
        end
        if (smp) begin
          col <= col + 4'd1;
          if (col == LAST) begin
            row      <= row + 5'd1;
            row_done <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/greedysnake_hdmi_capture.sv
// Rebuilds the 16x16 snake map from the rendered pixel stream and publishes
// it once per complete frame.
module greedysnake_hdmi_capture
  import greedysnake_pkg::*;
#(
  parameter int          H_RES       = H_ACTIVE,
  parameter int          V_RES       = V_ACTIVE,
  parameter int          MAP_X0      = MAP_ORG_X,
  parameter int          MAP_Y0      = MAP_ORG_Y,
  parameter int          CELL        = CELL_PX,
  parameter logic [23:0] SNAKE_COLOR = BLUE,
  parameter logic [23:0] POINT_COLOR = GRAY,
  parameter logic        VS_POL      = 1'b1
) (
  input  logic        I_pxl_clk,
  input  logic        I_rst_n,
  input  logic        I_en,
  input  logic        I_de,
  input  logic        I_hs,
  input  logic        I_vs,
  input  logic [23:0] I_color,
  output logic [15:0] snake_map_arr_0,
  output logic [15:0] snake_map_arr_1,
  output logic [15:0] snake_map_arr_2,
  output logic [15:0] snake_map_arr_3,
  output logic [15:0] snake_map_arr_4,
  output logic [15:0] snake_map_arr_5,
  output logic [15:0] snake_map_arr_6,
  output logic [15:0] snake_map_arr_7,
  output logic [15:0] snake_map_arr_8,
  output logic [15:0] snake_map_arr_9,
  output logic [15:0] snake_map_arr_10,
  output logic [15:0] snake_map_arr_11,
  output logic [15:0] snake_map_arr_12,
  output logic [15:0] snake_map_arr_13,
  output logic [15:0] snake_map_arr_14,
  output logic [15:0] snake_map_arr_15,
  output logic        O_frame_valid,
  output logic        O_frame_drop,
  output logic        O_err,
  output logic        O_busy
);

  cap_state_t          state;
  logic                de_d1, hs_d1, vs_d1, vs_d2;
  logic [23:0]         color_d1;
  logic                vs_edge;
  logic [15:0][15:0]   shadow, map_q;
  logic                err_shadow;
  logic [8:0]          sample_cnt;
  logic                smp;
  logic [3:0]          col, row;
  logic                is_snake, is_bad;

  // input register stage
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      de_d1    <= 1'b0;
      hs_d1    <= 1'b0;
      vs_d1    <= 1'b0;
      vs_d2    <= 1'b0;
      color_d1 <= '0;
    end else begin
      de_d1    <= I_de;
      hs_d1    <= I_hs;
      vs_d1    <= I_vs;
      vs_d2    <= vs_d1;
      color_d1 <= I_color;
    end
  end

  assign vs_edge  = (vs_d1 == VS_POL) && (vs_d2 != VS_POL);
  assign is_snake = (color_d1 == SNAKE_COLOR);
  assign is_bad   = !is_snake && (color_d1 != POINT_COLOR);
  assign O_busy   = (state == ACTIVE);

  // HS only ever lands in blanking, so it simply reinforces the line reload
  greedysnake_cell_sampler #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .MAP_X0(MAP_X0),
    .MAP_Y0(MAP_Y0),
    .CELL  (CELL)
  ) u_sampler (
    .I_pxl_clk(I_pxl_clk),
    .I_rst_n  (I_rst_n),
    .clr      ((state != ACTIVE) || vs_edge || !I_en),
    .line_rst (!de_d1 || hs_d1),
    .de       (de_d1),
    .en       ((state == ACTIVE) && !vs_edge && I_en),
    .smp      (smp),
    .col      (col),
    .row_idx  (row)
  );

  // capture FSM: shadow fill, frame commit/drop, output registers
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state         <= WAIT_VS;
      shadow        <= '0;
      err_shadow    <= 1'b0;
      sample_cnt    <= '0;
      map_q         <= '0;
      O_err         <= 1'b0;
      O_frame_valid <= 1'b0;
      O_frame_drop  <= 1'b0;
    end else begin
      O_frame_valid <= 1'b0;
      O_frame_drop  <= 1'b0;
      if (!I_en) begin
        state      <= WAIT_VS;
        shadow     <= '0;
        err_shadow <= 1'b0;
        sample_cnt <= '0;
      end else begin
        case (state)
          WAIT_VS: begin
            shadow     <= '0;
            err_shadow <= 1'b0;
            sample_cnt <= '0;
            if (vs_edge) state <= ACTIVE;
          end
          ACTIVE: begin
            if (vs_edge) begin
              if (sample_cnt == 9'd256) begin
                state <= COMMIT;
              end else begin
                O_frame_drop <= 1'b1;
                shadow       <= '0;
                err_shadow   <= 1'b0;
                sample_cnt   <= '0;
              end
            end else if (smp) begin
              shadow[row][4'd15 - col] <= is_snake;
              err_shadow               <= err_shadow | is_bad;
              sample_cnt               <= sample_cnt + 9'd1;
            end
          end
          COMMIT: begin
            map_q         <= shadow;
            O_err         <= err_shadow;
            O_frame_valid <= 1'b1;
            shadow        <= '0;
            err_shadow    <= 1'b0;
            sample_cnt    <= '0;
            state         <= ACTIVE;
          end
          default: state <= WAIT_VS;
        endcase
      end
    end
  end

  assign snake_map_arr_0  = map_q[0];
  assign snake_map_arr_1  = map_q[1];
  assign snake_map_arr_2  = map_q[2];
  assign snake_map_arr_3  = map_q[3];
  assign snake_map_arr_4  = map_q[4];
  assign snake_map_arr_5  = map_q[5];
  assign snake_map_arr_6  = map_q[6];
  assign snake_map_arr_7  = map_q[7];
  assign snake_map_arr_8  = map_q[8];
  assign snake_map_arr_9  = map_q[9];
  assign snake_map_arr_10 = map_q[10];
  assign snake_map_arr_11 = map_q[11];
  assign snake_map_arr_12 = map_q[12];
  assign snake_map_arr_13 = map_q[13];
  assign snake_map_arr_14 = map_q[14];
  assign snake_map_arr_15 = map_q[15];

endmodule

// File: tb/tb_greedysnake_hdmi_capture.sv
// Bench for the snake-map capture: renders frames of a scaled-down raster,
// predicts committed maps and pulses from the map/frame description.
module tb_greedysnake_hdmi_capture;

  localparam int H  = 40;
  localparam int V  = 38;
  localparam int X0 = 4;
  localparam int Y0 = 2;
  localparam int C  = 2;
  localparam int HT = H + 6;
  localparam int VB = 3;
  localparam logic [23:0] SNK = 24'hFF0000;
  localparam logic [23:0] PNT = 24'h646464;

  logic        clk = 1'b0;
  logic        I_rst_n, I_en, I_de, I_hs, I_vs;
  logic [23:0] I_color;
  logic [15:0] rows [16];
  logic        O_frame_valid, O_frame_drop, O_err, O_busy;

  always #5 clk = ~clk;

  greedysnake_hdmi_capture #(
    .H_RES(H), .V_RES(V), .MAP_X0(X0), .MAP_Y0(Y0), .CELL(C)
  ) dut (
    .I_pxl_clk(clk), .I_rst_n(I_rst_n), .I_en(I_en), .I_de(I_de),
    .I_hs(I_hs), .I_vs(I_vs), .I_color(I_color),
    .snake_map_arr_0(rows[0]),   .snake_map_arr_1(rows[1]),
    .snake_map_arr_2(rows[2]),   .snake_map_arr_3(rows[3]),
    .snake_map_arr_4(rows[4]),   .snake_map_arr_5(rows[5]),
    .snake_map_arr_6(rows[6]),   .snake_map_arr_7(rows[7]),
    .snake_map_arr_8(rows[8]),   .snake_map_arr_9(rows[9]),
    .snake_map_arr_10(rows[10]), .snake_map_arr_11(rows[11]),
    .snake_map_arr_12(rows[12]), .snake_map_arr_13(rows[13]),
    .snake_map_arr_14(rows[14]), .snake_map_arr_15(rows[15]),
    .O_frame_valid(O_frame_valid), .O_frame_drop(O_frame_drop),
    .O_err(O_err), .O_busy(O_busy)
  );

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // pulse monitor, sampled 1 time unit after each rising edge
  int cyc = 0, vs_cyc = 0, nvalid = 0, ndrop = 0, vld_lat = -1, drop_lat = -1;
  logic vs_prev = 1'b0;
  always @(posedge clk) begin
    #1;
    cyc++;
    if (I_vs && !vs_prev) vs_cyc = cyc;
    vs_prev = I_vs;
    if (O_frame_valid) begin nvalid++; vld_lat = cyc - vs_cyc; end
    if (O_frame_drop)  begin ndrop++;  drop_lat = cyc - vs_cyc; end
  end

  // reference model: frame-level view of what has been captured/committed
  logic [15:0] fmap [16];
  logic [15:0] m_map [16];
  logic [15:0] pend_map [16];
  bit m_active = 0, m_err = 0, pend_ok = 0, pend_err = 0;

  function automatic logic [23:0] pix(input int x, input int y, input bit ovr);
    int dx, dy;
    dx = x - X0;
    dy = y - Y0;
    if (dx >= 0 && dy >= 0 && dx < 16*C && dy < 16*C && dx % C == C/2 && dy % C == C/2) begin
      if (ovr && dx / C == 0 && dy / C == 0) return 24'h00FF00;
      return fmap[dy / C][15 - dx / C] ? SNK : PNT;
    end
    return 24'($urandom);
  endfunction

  task automatic drive(input logic de, input logic hs, input logic vs, input logic [23:0] c);
    @(negedge clk);
    I_de = de; I_hs = hs; I_vs = vs; I_color = c;
  endtask

  task automatic check_outputs();
    for (int r = 0; r < 16; r++) chk($sformatf("row%0d", r), rows[r], m_map[r]);
    chk("err", O_err, m_err);
  endtask

  task automatic send_frame(input int trunc, input bit ovr, input int rst_line);
    bit ev, ed;
    int nv0, nd0;
    ev = 0; ed = 0;
    if (!I_en) m_active = 0;
    else if (!m_active) m_active = 1;
    else if (pend_ok) begin ev = 1; m_map = pend_map; m_err = pend_err; end
    else ed = 1;
    nv0 = nvalid; nd0 = ndrop;
    for (int l = 0; l < VB; l++)
      for (int p = 0; p < HT; p++)
        drive(1'b0, (p > H && p < H + 3), (l == 0), 24'($urandom));
    chk("valid_cnt", nvalid - nv0, ev);
    chk("drop_cnt", ndrop - nd0, ed);
    if (ev) chk("valid_lat", vld_lat, 2);
    if (ed) chk("drop_lat", drop_lat, 1);
    check_outputs();
    pend_map = fmap;
    pend_err = 0;
    if (ovr) begin pend_map[0][15] = 1'b0; pend_err = 1; end
    pend_ok = (trunc > Y0 + 15*C + C/2);
    for (int y = 0; y < V; y++)
      for (int p = 0; p < HT; p++) begin
        drive((p < H) && (y < trunc), (p > H && p < H + 3), 1'b0,
              ((p < H) && (y < trunc)) ? pix(p, y, ovr) : 24'($urandom));
        if (y == rst_line && p == 0) begin
          #1 I_rst_n = 1'b0;
          #1;
          m_active = 0; m_err = 0;
          for (int r = 0; r < 16; r++) m_map[r] = '0;
          check_outputs();
          chk("rst_valid", O_frame_valid, 0);
          chk("rst_drop", O_frame_drop, 0);
          chk("rst_busy", O_busy, 0);
        end
        if (y == rst_line && p == 1) I_rst_n = 1'b1;
      end
    chk("busy", O_busy, m_active);
  endtask

  task automatic rand_map();
    for (int r = 0; r < 16; r++) fmap[r] = 16'($urandom);
  endtask

  initial begin
    I_rst_n = 1'b0; I_en = 1'b1; I_de = 1'b0; I_hs = 1'b0; I_vs = 1'b0; I_color = '0;
    for (int r = 0; r < 16; r++) m_map[r] = '0;
    repeat (3) @(negedge clk);
    check_outputs();
    chk("rst_valid", O_frame_valid, 0);
    chk("rst_drop", O_frame_drop, 0);
    chk("rst_busy", O_busy, 0);
    I_rst_n = 1'b1;

    for (int r = 0; r < 16; r++) fmap[r] = r[0] ? 16'h5555 : 16'hAAAA;
    send_frame(V, 0, -1);                       // F1 arms capture
    for (int r = 0; r < 16; r++) fmap[r] = '0;
    fmap[0] = 16'h8000; fmap[15] = 16'h0001;
    send_frame(V, 0, -1);                       // commits stripes
    rand_map(); send_frame(V, 1, -1);           // commits corners; bad centre pixel
    rand_map(); send_frame(V, 0, -1);           // commits with err
    rand_map(); send_frame(Y0 + 15*C, 0, -1);   // clean commit; truncated frame
    rand_map(); send_frame(V, 0, -1);           // drop
    rand_map(); send_frame(V, 0, 20);           // commit, then reset mid-frame
    rand_map(); send_frame(V, 0, -1);           // re-arms, no pulse
    rand_map(); send_frame(V, 0, -1);           // commit
    @(negedge clk); I_en = 1'b0;
    rand_map(); send_frame(V, 0, -1);           // disabled: no pulses, held
    @(negedge clk); I_en = 1'b1;
    rand_map(); send_frame(V, 0, -1);           // re-arms
    rand_map(); send_frame(V, 0, -1);           // commit
    rand_map(); send_frame(V, 0, -1);           // commit

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
